// File: rtl/series_accum_ctrl.sv
// series_accum_ctrl: sequences one shared float ALU to accumulate a stream of series terms.
// Optional abort input is compiled in when SERIES_ACC_ABORT_EN is defined.
module series_accum_ctrl #(
   parameter int unsigned CNT_W   = 4,
   parameter logic [4:0]  OP_ADD  = 5'b10001,
   parameter logic [4:0]  OP_NOP  = 5'b00000,
   parameter int          ALU_LAT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef SERIES_ACC_ABORT_EN
   input  logic              abort,
`endif
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_count,
   input  logic              term_valid,
   input  logic [31:0]       term_data,
   output logic              term_ready,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [4:0]        alu_op,
   input  logic [63:0]       alu_out,
   output logic              busy,
   output logic              done,
   output logic [31:0]       sum
);

   // state     | meaning
   // IDLE      | waiting for start
   // FIRST     | first term loads the accumulator directly, no ALU op
   // WAIT_TERM | waiting for the next term to add
   // ISSUE     | operands and add opcode presented to the ALU
   // WAIT_ALU  | ALU_LAT extra cycles for a pipelined ALU
   // CAPTURE   | ALU result written into the accumulator
   // FINISH    | one-cycle done pulse
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FIRST     = 3'd1,
      S_WAIT_TERM = 3'd2,
      S_ISSUE     = 3'd3,
      S_WAIT_ALU  = 3'd4,
      S_CAPTURE   = 3'd5,
      S_FINISH    = 3'd6
   } state_t;

   localparam int          LAT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = (ALU_LAT > 0) ? LAT_W'(ALU_LAT - 1) : '0;

   state_t             r_state;
   logic [CNT_W-1:0]   r_rem;
   logic [LAT_W-1:0]   r_lat;
   logic [31:0]        r_sum;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [4:0]         r_op;
   logic               r_term_ready;
   logic               r_busy;
   logic               r_done;

   state_t             w_nxt_state;
   logic [CNT_W-1:0]   w_nxt_rem;
   logic [CNT_W-1:0]   w_rem_dec;
   logic [LAT_W-1:0]   w_nxt_lat;
   logic [31:0]        w_nxt_sum;
   logic [31:0]        w_nxt_a;
   logic [31:0]        w_nxt_b;
   logic [4:0]         w_nxt_op;
   logic               w_hs;
   logic               w_abort;
   logic               w_unused_alu_hi;

`ifdef SERIES_ACC_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // Only the low word of the ALU result carries the float sum.
   assign w_unused_alu_hi = &{1'b0, alu_out[63:32]};

   assign w_hs      = r_term_ready & term_valid;
   assign w_rem_dec = (r_rem != '0) ? r_rem - 1'b1 : r_rem;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_rem   = r_rem;
      w_nxt_lat   = r_lat;
      w_nxt_sum   = r_sum;
      w_nxt_a     = r_a;
      w_nxt_b     = r_b;
      w_nxt_op    = r_op;

      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nxt_rem   = cfg_count;
               w_nxt_sum   = '0;
               w_nxt_state = (cfg_count == '0) ? S_FINISH : S_FIRST;
            end
         end
         S_FIRST: begin
            if (w_hs) begin
               w_nxt_sum   = term_data;
               w_nxt_rem   = w_rem_dec;
               w_nxt_state = (w_rem_dec == '0) ? S_FINISH : S_WAIT_TERM;
            end
         end
         S_WAIT_TERM: begin
            if (w_hs) begin
               w_nxt_a     = r_sum;
               w_nxt_b     = term_data;
               w_nxt_op    = OP_ADD;
               w_nxt_state = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ALU_LAT > 0) begin
               w_nxt_lat   = LAT_LOAD;
               w_nxt_state = S_WAIT_ALU;
            end else begin
               w_nxt_state = S_CAPTURE;
            end
         end
         S_WAIT_ALU: begin
            if (r_lat == '0) begin
               w_nxt_state = S_CAPTURE;
            end else begin
               w_nxt_lat = r_lat - 1'b1;
            end
         end
         S_CAPTURE: begin
            w_nxt_sum   = alu_out[31:0];
            w_nxt_op    = OP_NOP;
            w_nxt_rem   = w_rem_dec;
            w_nxt_state = (w_rem_dec == '0) ? S_FINISH : S_WAIT_TERM;
         end
         S_FINISH: begin
            w_nxt_state = S_IDLE;
         end
         default: begin
            w_nxt_state = S_IDLE;
         end
      endcase

      // Abort overrides whatever the state logic decided, keeping the partial sum.
      if (w_abort && (r_state != S_IDLE)) begin
         w_nxt_state = S_IDLE;
         w_nxt_rem   = r_rem;
         w_nxt_lat   = r_lat;
         w_nxt_sum   = r_sum;
         w_nxt_a     = r_a;
         w_nxt_b     = r_b;
         w_nxt_op    = OP_NOP;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_rem        <= '0;
         r_lat        <= '0;
         r_sum        <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= OP_NOP;
         r_term_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_rem        <= w_nxt_rem;
         r_lat        <= w_nxt_lat;
         r_sum        <= w_nxt_sum;
         r_a          <= w_nxt_a;
         r_b          <= w_nxt_b;
         r_op         <= w_nxt_op;
         r_term_ready <= (w_nxt_state == S_FIRST) || (w_nxt_state == S_WAIT_TERM);
         r_busy       <= (w_nxt_state != S_IDLE) && (w_nxt_state != S_FINISH);
         r_done       <= (w_nxt_state == S_FINISH);
      end
   end

   assign term_ready = r_term_ready;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign alu_op     = r_op;
   assign busy       = r_busy;
   assign done       = r_done;
   assign sum        = r_sum;

endmodule

// File: tb/tb_series_accum_ctrl.sv
// tb_series_accum_ctrl: randomized self-checking bench for series_accum_ctrl with a
// combinational ALU (ALU_LAT=0) and a two-stage pipelined ALU (ALU_LAT=2).
module tb_series_accum_ctrl;
   localparam logic [4:0] OP_ADD = 5'b10001;
   localparam logic [4:0] OP_NOP = 5'b00000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start;
   logic        sel;
   logic [3:0]  cfg_count;
   logic        term_valid;
   logic [31:0] term_data;
`ifdef SERIES_ACC_ABORT_EN
   logic        abort;
`endif
   logic        start0, start2;
   assign start0 = start & ~sel;
   assign start2 = start & sel;

   logic        rdy0, busy0, done0, rdy2, busy2, done2;
   logic [31:0] a0, b0, sum0, a2, b2, sum2;
   logic [4:0]  op0, op2;
   logic [63:0] alu0, alu2;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          hs_cnt = 0, hs_last = 0, done_cnt = 0, done_cyc = 0;
   int          rdy_cycles = 0, add_cycles = 0;
   logic [31:0] q_terms[$];

   function automatic real f2r(input logic [31:0] f);
      real m;
      int  e;
      if (f[30:0] == 31'd0) return 0.0;
      m = 1.0 + real'(f[22:0]) / 8388608.0;
      e = int'(f[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return f[31] ? -m : m;
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic        s;
      real         m;
      int          e;
      logic [22:0] fr;
      if (r == 0.0) return 32'h0;
      s = (r < 0.0);
      m = s ? -r : r;
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      fr = 23'(longint'((m - 1.0) * 8388608.0));
      return {s, 8'(e + 127), fr};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
      return r2f(f2r(x) + f2r(y));
   endfunction

   logic [31:0] alu_lo0, p1, p2;
   always_comb alu_lo0 = (op0 == OP_ADD) ? fadd(a0, b0) : 32'hFFFF_FFFF;
   assign alu0 = {32'hA5A5_A5A5, alu_lo0};
   always @(posedge clk) begin
      p1 <= (op2 == OP_ADD) ? fadd(a2, b2) : 32'hFFFF_FFFF;
      p2 <= p1;
   end
   assign alu2 = {32'h5A5A_5A5A, p2};

   series_accum_ctrl #(.CNT_W(4), .ALU_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
`ifdef SERIES_ACC_ABORT_EN
      .abort(abort),
`endif
      .start(start0), .cfg_count(cfg_count), .term_valid(term_valid), .term_data(term_data),
      .term_ready(rdy0), .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_out(alu0),
      .busy(busy0), .done(done0), .sum(sum0));

   series_accum_ctrl #(.CNT_W(4), .ALU_LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
`ifdef SERIES_ACC_ABORT_EN
      .abort(abort),
`endif
      .start(start2), .cfg_count(cfg_count), .term_valid(term_valid), .term_data(term_data),
      .term_ready(rdy2), .alu_a(a2), .alu_b(b2), .alu_op(op2), .alu_out(alu2),
      .busy(busy2), .done(done2), .sum(sum2));

   logic        w_rdy, w_busy, w_done;
   logic [31:0] w_sum;
   logic [4:0]  w_op;
   assign w_rdy  = sel ? rdy2  : rdy0;
   assign w_busy = sel ? busy2 : busy0;
   assign w_done = sel ? done2 : done0;
   assign w_sum  = sel ? sum2  : sum0;
   assign w_op   = sel ? op2   : op0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && term_valid && w_rdy) begin
         hs_cnt  = hs_cnt + 1;
         hs_last = cyc;
      end
   end

   always @(negedge clk) begin
      if (w_done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
      if (w_rdy) rdy_cycles = rdy_cycles + 1;
      if (w_op == OP_ADD) add_cycles = add_cycles + 1;
   end

   // Presents q_terms[0..n-1] one at a time, holding each until it is accepted.
   task automatic feed_terms(input int n, input bit gaps, input bit poke, output int t_first);
      int budget;
      bit ok;
      t_first = 0;
      for (int i = 0; i < n; i++) begin
         term_data = q_terms[i];
         budget = 0;
         forever begin
            term_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (poke) start = $urandom_range(0, 1) != 0;
            ok = term_valid && w_rdy;
            @(negedge clk);
            if (ok) break;
            budget++;
            if (budget > 200) break;
         end
         if (budget > 200) begin
            total++; bad++;
            $display("FAIL feed_timeout term=%0d got no term_ready within 200 cycles", i);
            break;
         end
         if (i == 0) t_first = hs_last;
      end
      term_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic do_run(input int n, input logic [31:0] exp_sum, input bit gaps,
                         input bit poke, input int lat, input string name);
      int hs0, dn0, rd0, ad0, t_first, t_start, budget, exp_adds;
      @(negedge clk);
      hs0 = hs_cnt; dn0 = done_cnt; rd0 = rdy_cycles; ad0 = add_cycles;
      cfg_count = 4'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t_start = cyc;
      feed_terms(n, gaps, poke, t_first);
      budget = 0;
      while (done_cnt == dn0 && budget < 100) begin @(negedge clk); budget++; end
      repeat (3) @(negedge clk);
      total++;
      if (done_cnt == dn0) begin bad++; $display("FAIL %s done_timeout", name); end
      total++;
      if (w_sum !== exp_sum) begin bad++; $display("FAIL %s sum got=%h exp=%h", name, w_sum, exp_sum); end
      total++;
      if (done_cnt - dn0 !== 1) begin bad++; $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt - dn0); end
      total++;
      if (hs_cnt - hs0 !== n) begin bad++; $display("FAIL %s terms_taken got=%0d exp=%0d", name, hs_cnt - hs0, n); end
      total++;
      if (w_busy !== 1'b0) begin bad++; $display("FAIL %s busy_after got=%b exp=0", name, w_busy); end
      exp_adds = (n > 1) ? (n - 1) * (lat + 2) : 0;
      total++;
      if (add_cycles - ad0 !== exp_adds) begin
         bad++; $display("FAIL %s add_op_cycles got=%0d exp=%0d", name, add_cycles - ad0, exp_adds);
      end
      total++;
      if (n == 0) begin
         if (done_cyc - t_start !== 0 || rdy_cycles - rd0 !== 0) begin
            bad++; $display("FAIL %s zero_count done_lag=%0d ready_cycles=%0d exp 0/0", name,
                            done_cyc - t_start, rdy_cycles - rd0);
         end
      end else if (n == 1) begin
         if (done_cyc - hs_last !== 0) begin bad++; $display("FAIL %s done_lag got=%0d exp=0", name, done_cyc - hs_last); end
      end else begin
         if (done_cyc - hs_last !== lat + 2) begin
            bad++; $display("FAIL %s done_lag got=%0d exp=%0d", name, done_cyc - hs_last, lat + 2);
         end
      end
      if (!gaps && n > 0) begin
         total++;
         if (done_cyc - t_first !== (n - 1) * (lat + 3)) begin
            bad++; $display("FAIL %s first_to_done got=%0d exp=%0d", name, done_cyc - t_first, (n - 1) * (lat + 3));
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; term_valid = 1'b0; term_data = '0; cfg_count = '0; sel = 1'b0;
`ifdef SERIES_ACC_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      total++;
      if ({rdy0, busy0, done0, sum0, a0, b0, op0} !== '0) begin
         bad++; $display("FAIL reset_dut0 got rdy=%b busy=%b done=%b sum=%h a=%h b=%h op=%b exp all 0",
                         rdy0, busy0, done0, sum0, a0, b0, op0);
      end
      total++;
      if ({rdy2, busy2, done2, sum2, a2, b2, op2} !== '0) begin
         bad++; $display("FAIL reset_dut2 got rdy=%b busy=%b done=%b sum=%h op=%b exp all 0",
                         rdy2, busy2, done2, sum2, op2);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_spec_sums(input bit gaps, input bit poke);
      q_terms = '{32'h3F80_0000, 32'h4188_0000};
      do_run(2, 32'h4190_0000, gaps, poke, 0, gaps ? "two_terms_gaps" : "two_terms");
      q_terms = '{32'h3F80_0000, 32'h4188_0000, 32'h4310_8000};
      do_run(3, 32'h4322_8000, gaps, poke, 0, gaps ? "three_terms_gaps" : "three_terms");
   endtask

   task automatic test_edge_counts();
      q_terms = '{};
      do_run(0, 32'h0, 1'b0, 1'b0, 0, "count_zero");
      q_terms = '{32'h4188_0000};
      do_run(1, 32'h4188_0000, 1'b0, 1'b0, 0, "count_one");
   endtask

   task automatic test_random(input int iters, input int lat);
      int n, k, acc;
      for (int it = 0; it < iters; it++) begin
         n = $urandom_range(0, 8);
         acc = 0;
         q_terms = '{};
         for (int j = 0; j < n; j++) begin
            k = $urandom_range(1, 100);
            acc += k;
            q_terms.push_back(r2f(real'(k)));
         end
         do_run(n, r2f(real'(acc)), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, lat, "random");
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      cfg_count = 4'd0; start = 1'b1;
      @(negedge clk);
      total++;
      if (done0 !== 1'b1) begin bad++; $display("FAIL finish_entry done got=%b exp=1", done0); end
      cfg_count = 4'd3;
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({busy0, rdy0, done0} !== 3'b000) begin
         bad++; $display("FAIL start_in_finish busy/rdy/done got=%b%b%b exp=000", busy0, rdy0, done0);
      end
      q_terms = '{32'h4000_0000, 32'h4040_0000};
      do_run(2, 32'h40A0_0000, 1'b0, 1'b0, 0, "back_to_back");
   endtask

   task automatic test_reset_mid();
      int tf, dn0;
      sel = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cfg_count = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      q_terms = '{32'h3F80_0000, 32'h4188_0000, 32'h4000_0000};
      feed_terms(2, 1'b0, 1'b0, tf);
      @(negedge clk);
      total++;
      if (op2 !== OP_ADD) begin bad++; $display("FAIL wait_alu_op got=%b exp=%b", op2, OP_ADD); end
      dn0 = done_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if ({rdy2, busy2, done2, sum2, a2, b2, op2} !== '0) begin
         bad++; $display("FAIL reset_mid got rdy=%b busy=%b done=%b sum=%h a=%h b=%h op=%b exp all 0",
                         rdy2, busy2, done2, sum2, a2, b2, op2);
      end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      total++;
      if (done_cnt !== dn0 || busy2 !== 1'b0) begin
         bad++; $display("FAIL reset_mid_after done_pulses=%0d busy=%b exp 0/0", done_cnt - dn0, busy2);
      end
      q_terms = '{32'h3F80_0000, 32'h4188_0000, 32'h4310_8000};
      do_run(3, 32'h4322_8000, 1'b0, 1'b0, 2, "lat2_three_terms");
      test_random(4, 2);
      sel = 1'b0;
   endtask

`ifdef SERIES_ACC_ABORT_EN
   task automatic test_abort();
      int tf, dn0;
      sel = 1'b0;
      @(negedge clk);
      cfg_count = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      q_terms = '{32'h3F80_0000, 32'h4188_0000, 32'h4000_0000};
      feed_terms(2, 1'b0, 1'b0, tf);
      total++;
      if (op0 !== OP_ADD) begin bad++; $display("FAIL abort_issue_op got=%b exp=%b", op0, OP_ADD); end
      dn0 = done_cnt;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++;
      if ({busy0, rdy0, op0} !== {1'b0, 1'b0, OP_NOP} || sum0 !== 32'h3F80_0000) begin
         bad++; $display("FAIL abort_state busy=%b rdy=%b op=%b sum=%h exp 0 0 %b 3f800000",
                         busy0, rdy0, op0, sum0, OP_NOP);
      end
      repeat (5) @(negedge clk);
      total++;
      if (done_cnt !== dn0) begin bad++; $display("FAIL abort_done got=%0d exp=0", done_cnt - dn0); end
      q_terms = '{32'h3F80_0000, 32'h4188_0000};
      do_run(2, 32'h4190_0000, 1'b0, 1'b0, 0, "after_abort");
   endtask
`endif

   initial begin
      test_reset();
      test_spec_sums(1'b0, 1'b0);
      test_edge_counts();
      test_spec_sums(1'b1, 1'b1);
      test_back_to_back();
      test_random(10, 0);
`ifdef SERIES_ACC_ABORT_EN
      test_abort();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $fatal(1, "global timeout");
   end
endmodule
